// File: rtl/idct_prod_accum.sv
// Sums TAPS signed products per IDCT coefficient, then rounds, shifts and saturates
// the sum into one output coefficient, framed in rows of eight.
module idct_prod_accum #(
    parameter int P_BITWIDTH   = 32,
    parameter int TAPS         = 8,
    parameter int SHIFT        = 8,
    parameter int OUT_BITWIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic signed [P_BITWIDTH-1:0]   P,
    input  logic                           p_valid,
    output logic                           p_ready,
    input  logic                           clr,
    output logic signed [OUT_BITWIDTH-1:0] out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           sat
);

    localparam int ACC_W = P_BITWIDTH + 3;
    localparam int RND_W = ACC_W + 1;
    localparam int CNT_W = $clog2(TAPS + 1);

    localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) << (SHIFT - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX  = (RND_W'(1) << (OUT_BITWIDTH - 1)) - RND_W'(1);
    localparam logic signed [RND_W-1:0] SAT_MIN  = -(RND_W'(1) << (OUT_BITWIDTH - 1));

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        ROUND = 2'b10
    } state_t;

    state_t                          state_q, state_d;
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]                tap_cnt_q, tap_cnt_d;
    logic [2:0]                      row_cnt_q, row_cnt_d;
    logic signed [OUT_BITWIDTH-1:0]  out_data_q, out_data_d;
    logic                            out_valid_q, out_valid_d;
    logic                            out_last_q, out_last_d;
    logic                            sat_q, sat_d;

    logic                            accept;
    logic                            load;
    logic signed [ACC_W-1:0]         p_ext;
    logic signed [RND_W-1:0]         rnd_sum;
    logic signed [RND_W-1:0]         rnd_shift;
    logic                            clip_hi;
    logic                            clip_lo;

    // p_ready is forced high while reset is asserted, before the state register settles.
    assign p_ready = !rstN || (state_q != ROUND);
    assign accept  = p_valid && (state_q != ROUND);
    assign p_ext   = {{3{P[P_BITWIDTH-1]}}, P};

    assign rnd_sum   = RND_W'(acc_q) + RND_HALF;
    assign rnd_shift = rnd_sum >>> SHIFT;
    assign clip_hi   = rnd_shift > SAT_MAX;
    assign clip_lo   = rnd_shift < SAT_MIN;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_cnt_q   <= '0;
            row_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_cnt_q   <= tap_cnt_d;
            row_cnt_q   <= row_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_cnt_d   = tap_cnt_q;
        row_cnt_d   = row_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        sat_d       = sat_q;
        load        = 1'b0;

        // clr aborts the accumulation but leaves the output register and row count alone.
        if (clr) begin
            state_d   = IDLE;
            acc_d     = '0;
            tap_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d     = p_ext;
                        tap_cnt_d = CNT_W'(1);
                        state_d   = ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d     = acc_q + p_ext;
                        tap_cnt_d = tap_cnt_q + CNT_W'(1);
                        if (tap_cnt_q == CNT_W'(TAPS - 1)) begin
                            state_d = ROUND;
                        end
                    end
                end
                ROUND: begin
                    if (!out_valid_q || out_ready) begin
                        load      = 1'b1;
                        acc_d     = '0;
                        tap_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A fresh load wins over the pop of the previous coefficient.
        if (load) begin
            out_valid_d = 1'b1;
            out_last_d  = (row_cnt_q == 3'd7);
            row_cnt_d   = row_cnt_q + 3'd1;
            sat_d       = clip_hi || clip_lo;
            if (clip_hi) begin
                out_data_d = SAT_MAX[OUT_BITWIDTH-1:0];
            end else if (clip_lo) begin
                out_data_d = SAT_MIN[OUT_BITWIDTH-1:0];
            end else begin
                out_data_d = rnd_shift[OUT_BITWIDTH-1:0];
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_idct_prod_accum.sv
// Directed bench for idct_prod_accum: expected coefficients are queued as rows are
// issued and a monitor pops and compares them whenever the DUT hands one over.
module tb_idct_prod_accum;

    logic               clk = 1'b0;
    logic               rstN;
    logic signed [31:0] P;
    logic               p_valid;
    logic               p_ready;
    logic               clr;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               sat;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        sat;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   errors = 0;
    int   expRow = 0;

    idct_prod_accum #(
        .P_BITWIDTH  (32),
        .TAPS        (8),
        .SHIFT       (8),
        .OUT_BITWIDTH(16)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .P        (P),
        .p_valid  (p_valid),
        .p_ready  (p_ready),
        .clr      (clr),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, so out_ready is stable at the falling edge.
    always @(negedge clk) begin
        if (rstN && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                monE = expQ.pop_front();
                checkOutput("out_data", {16'h0, out_data}, {16'h0, monE.data});
                checkOutput("out_last", {31'h0, out_last}, {31'h0, monE.last});
                checkOutput("sat", {31'h0, sat}, {31'h0, monE.sat});
            end
        end
    end

    task automatic applyStimulus(input logic signed [31:0] val);
        logic ok;
        logic done;
        done    = 1'b0;
        P       = val;
        p_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            ok = p_ready;
            @(posedge clk);
            #1;
            if (ok) done = 1'b1;
        end
        p_valid = 1'b0;
        P       = 'x;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no accept expected accept of %0h", val);
        end
    endtask

    task automatic pushExp(input logic [15:0] data, input logic s);
        exp_t e;
        e.data = data;
        e.last = (expRow == 7);
        e.sat  = s;
        expQ.push_back(e);
        expRow = (expRow + 1) % 8;
    endtask

    task automatic sendRow(input logic signed [31:0] first, input logic signed [31:0] rest,
                           input logic [15:0] data, input logic s);
        pushExp(data, s);
        applyStimulus(first);
        repeat (7) applyStimulus(rest);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100 && expQ.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain", expQ.size(), 0);
    endtask

    initial begin
        rstN      = 1'b0;
        p_valid   = 1'b0;
        P         = 'x;
        clr       = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("p_ready_in_reset", {31'h0, p_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("rst_out_data", {16'h0, out_data}, 32'h0);
        checkOutput("rst_out_last", {31'h0, out_last}, 32'h0);
        checkOutput("rst_sat", {31'h0, sat}, 32'h0);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Basic sum and latency: one edge after the 8th accept the result is visible.
        sendRow(256, 256, 16'd8, 1'b0);
        checkOutput("lat_valid_low", {31'h0, out_valid}, 32'h0);
        checkOutput("lat_p_ready_round", {31'h0, p_ready}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("lat_valid_high", {31'h0, out_valid}, 32'h1);
        checkOutput("lat_data", {16'h0, out_data}, 32'h8);

        sendRow(128, 0, 16'd1, 1'b0);
        sendRow(-129, 0, 16'hFFFF, 1'b0);
        sendRow(-128, 0, 16'd0, 1'b0);
        sendRow(32'h7FFF_FFFF, 32'h7FFF_FFFF, 16'h7FFF, 1'b1);
        sendRow(32'h8000_0000, 32'h8000_0000, 16'h8000, 1'b1);
        waitDrain();

        // Backpressure: a second row completes while the first result is stalled.
        out_ready = 1'b0;
        sendRow(256, 256, 16'd8, 1'b0);
        sendRow(-512, -512, 16'hFFF0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_p_ready", {31'h0, p_ready}, 32'h0);
        checkOutput("bp_hold_data", {16'h0, out_data}, 32'h8);
        checkOutput("bp_hold_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_reload_valid", {31'h0, out_valid}, 32'h1);
        checkOutput("bp_reload_data", {16'h0, out_data}, 32'h0000FFF0);
        waitDrain();

        // Row framing: eight full rows back-to-back, last only on the 8th.
        for (int r = 0; r < 8; r++) begin
            sendRow(256 * (r + 1), 256 * (r + 1), 16'(8 * (r + 1)), 1'b0);
        end
        waitDrain();

        // Reset mid-accumulation.
        repeat (5) applyStimulus(256);
        rstN = 1'b0;
        #1;
        checkOutput("abort_p_ready_in_reset", {31'h0, p_ready}, 32'h1);
        @(posedge clk);
        #1;
        checkOutput("abort_rst_valid", {31'h0, out_valid}, 32'h0);
        checkOutput("abort_rst_data", {16'h0, out_data}, 32'h0);
        rstN   = 1'b1;
        expRow = 0;
        @(posedge clk);
        #1;
        sendRow(256, 256, 16'd8, 1'b0);
        waitDrain();

        // clr mid-accumulation, with a product presented in the same cycle.
        repeat (3) applyStimulus(1000);
        P       = 5000;
        p_valid = 1'b1;
        clr     = 1'b1;
        @(posedge clk);
        #1;
        clr     = 1'b0;
        p_valid = 1'b0;
        P       = 'x;
        sendRow(256, 256, 16'd8, 1'b0);
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
